// File: rtl/mem_pkg.sv
`default_nettype none
// ****************************************************************************
// * mem_pkg : shared memory-stage types (request params, sizes, fault causes) *
// * Revision: 1.0                                                             *
// ****************************************************************************
package mem_pkg;

  typedef struct packed {
    logic       op;             // 1 = read, 0 = write
    logic [1:0] access_size;
    logic       read_unsigned;
  } mem_params_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS_ERR  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } mem_fault_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } mau_state_t;

  localparam logic MEM_OP_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ****************************************************************************
// * mem_lane_align : byte-lane enables, store shift, load extract/extend      *
// * Revision: 1.0                                                             *
// ****************************************************************************
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        read_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] rdata_sh;

  assign shamt    = {offset, 3'b000};
  assign wdata_sh = wdata << shamt;
  assign rdata_sh = rdata >> shamt;

  always_comb begin
    byte_en    = 4'b0000;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        byte_en   = 4'b0001 << offset;
        rdata_ext = read_unsigned ? {24'h0, rdata_sh[7:0]}
                                  : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      MEM_HALF: begin
        misaligned = offset[0];
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        rdata_ext  = read_unsigned ? {16'h0, rdata_sh[15:0]}
                                   : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      end
      MEM_WORD: begin
        misaligned = (offset != 2'b00);
        byte_en    = 4'b1111;
        rdata_ext  = rdata;
      end
      default: misaligned = 1'b1;  // reserved size is always illegal
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ****************************************************************************
// * mem_access_unit : one req/ack bus transaction per load/store request      *
// * Revision: 1.0                                                             *
// ****************************************************************************
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_params_t mem_params,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_cause
);

  mau_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [1:0]  resp_cause_q, resp_cause_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        idle;
  logic [1:0]  al_size, al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_misaligned;
  logic        timeout_hit;

  assign idle = (state_q == ST_IDLE);

  // The aligner sees the incoming request while idle, the latched one otherwise.
  assign al_size = idle ? mem_params.access_size   : size_q;
  assign al_off  = idle ? req_addr[1:0]            : off_q;
  assign al_uns  = idle ? mem_params.read_unsigned : uns_q;

  mem_lane_align u_align (
    .size          (al_size),
    .offset        (al_off),
    .read_unsigned (al_uns),
    .wdata         (req_wdata),
    .rdata         (bus_rdata),
    .byte_en       (al_be),
    .wdata_sh      (al_wdata),
    .rdata_ext     (al_rdata),
    .misaligned    (al_misaligned)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    size_d       = size_q;
    off_d        = off_q;
    uns_d        = uns_q;
    resp_valid_d = 1'b0;
    resp_fault_d = resp_fault_q;
    resp_cause_d = resp_cause_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (al_misaligned) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_cause_d = CAUSE_MISALIGN;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = 32'h0;
            bus_req_d   = 1'b1;
            bus_we_d    = (mem_params.op != MEM_OP_READ);
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_be_d    = al_be;
            bus_wdata_d = al_wdata;
            size_d      = mem_params.access_size;
            off_d       = req_addr[1:0];
            uns_d       = mem_params.read_unsigned;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 32'd1;
        // Priority: error, then ack, then timeout (ack on the limit cycle succeeds).
        if (bus_err) begin
          state_d      = ST_DONE;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_cause_d = CAUSE_BUS_ERR;
          resp_rdata_d = 32'h0;
        end else if (bus_ack) begin
          state_d      = ST_DONE;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_cause_d = CAUSE_NONE;
          resp_rdata_d = bus_we_q ? 32'h0 : al_rdata;
        end else if (timeout_hit) begin
          state_d      = ST_DONE;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          resp_cause_d = CAUSE_TIMEOUT;
          resp_rdata_d = 32'h0;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        cnt_d     = 32'h0;
        bus_req_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'h0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_be_q     <= 4'h0;
      bus_wdata_q  <= 32'h0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= 2'b00;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      size_q       <= size_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready   = idle;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_byte_en = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_fault  = resp_fault_q;
  assign resp_cause  = resp_cause_q;

endmodule
`default_nettype wire
